// File: rtl/johnson_phase_monitor.sv
// Checks a 4-bit Johnson counter stream, decodes one-hot phase, acquires lock, counts revolutions and faults.
// Latency 1 clk from q_in to all outputs; no backpressure (en only qualifies samples). Option: JPM_STICKY_ERR_EN.
module johnson_phase_monitor #(
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8,
    parameter int REV_W    = 8
) (
    input  logic             clk,
    input  logic             start_n,
    input  logic             en,
    input  logic [3:0]       q_in,
    output logic [7:0]       phase,
    output logic [2:0]       phase_idx,
    output logic             locked,
    output logic             wrap,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [REV_W-1:0] rev_cnt
);

    typedef enum logic [1:0] {SEARCH, ACQ, LOCK} state_t;

    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [REV_W-1:0] REV_ONE  = REV_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       phase_q, phase_d;
    logic [3:0]       good_q, good_d;
    logic             locked_q, locked_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;

    logic             code_vld;
    logic [2:0]       code_idx;
    logic [7:0]       code_hot;
    logic             succ;
    logic             fault;

    always_comb begin
        code_vld = 1'b1;
        code_idx = 3'd0;
        case (q_in)
            4'b0000: code_idx = 3'd0;
            4'b0001: code_idx = 3'd1;
            4'b0011: code_idx = 3'd2;
            4'b0111: code_idx = 3'd3;
            4'b1111: code_idx = 3'd4;
            4'b1110: code_idx = 3'd5;
            4'b1100: code_idx = 3'd6;
            4'b1000: code_idx = 3'd7;
            default: code_vld = 1'b0;
        endcase
        code_hot = 8'(1) << code_idx;
        // A repeated code is deliberately not a successor: a stalled counter is a fault.
        succ     = code_vld && (code_idx == 3'(idx_q + 3'd1));
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        good_d    = good_q;
        wrap_d    = 1'b0;
        fault     = 1'b0;
        err_cnt_d = err_cnt_q;
        rev_cnt_d = rev_cnt_q;

        if (en) begin
            case (state_q)
                SEARCH: begin
                    if (code_vld) begin
                        idx_d   = code_idx;
                        phase_d = code_hot;
                        good_d  = 4'd0;
                        state_d = ACQ;
                    end else begin
                        phase_d = 8'd0;
                    end
                end
                ACQ: begin
                    if (!code_vld) begin
                        phase_d = 8'd0;
                        good_d  = 4'd0;
                        state_d = SEARCH;
                    end else if (succ) begin
                        idx_d   = code_idx;
                        phase_d = code_hot;
                        good_d  = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_TGT) begin
                            state_d = LOCK;
                        end
                    end else begin
                        idx_d   = code_idx;
                        phase_d = code_hot;
                        good_d  = 4'd0;
                    end
                end
                LOCK: begin
                    if (succ) begin
                        idx_d   = code_idx;
                        phase_d = code_hot;
                        if (idx_q == 3'd7) begin
                            wrap_d    = 1'b1;
                            rev_cnt_d = rev_cnt_q + REV_ONE;
                        end
                    end else begin
                        fault = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_ONE;
                        end
                        if (code_vld) begin
                            idx_d   = code_idx;
                            phase_d = code_hot;
                            good_d  = 4'd0;
                            state_d = ACQ;
                        end else begin
                            phase_d = 8'd0;
                            state_d = SEARCH;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    phase_d = 8'd0;
                    good_d  = 4'd0;
                end
            endcase
        end

        locked_d = (state_d == LOCK);
`ifdef JPM_STICKY_ERR_EN
        err_d    = err_q | fault;
`else
        err_d    = fault;
`endif
    end

    always_ff @(posedge clk) begin
        if (!start_n) begin
            state_q   <= SEARCH;
            idx_q     <= 3'd0;
            phase_q   <= 8'd0;
            good_q    <= 4'd0;
            locked_q  <= 1'b0;
            wrap_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            rev_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            good_q    <= good_d;
            locked_q  <= locked_d;
            wrap_q    <= wrap_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            rev_cnt_q <= rev_cnt_d;
        end
    end

    assign phase     = phase_q;
    assign phase_idx = idx_q;
    assign locked    = locked_q;
    assign wrap      = wrap_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign rev_cnt   = rev_cnt_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Bench for johnson_phase_monitor: directed vector table, randomized model check, saturation and reset corners.
module tb_johnson_phase_monitor;

    localparam int LOCK_CNT = 4;

    logic       clk = 1'b0;
    logic       start_n = 1'b1;
    logic       en = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic [7:0] phase;
    logic [2:0] phase_idx;
    logic       locked, wrap, err;
    logic [7:0] err_cnt, rev_cnt;

    int n_vec = 0;
    int n_bad = 0;

    johnson_phase_monitor #(.LOCK_CNT(LOCK_CNT), .ERR_W(8), .REV_W(8)) dut (
        .clk(clk), .start_n(start_n), .en(en), .q_in(q_in),
        .phase(phase), .phase_idx(phase_idx), .locked(locked), .wrap(wrap),
        .err(err), .err_cnt(err_cnt), .rev_cnt(rev_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural reference: the legal sequence as a list, modes as plain integers.
    int codes[8] = '{0, 1, 3, 7, 15, 14, 12, 8};
    int m_mode, m_idx, m_good, m_errc, m_rev;
    bit m_locked, m_wrap, m_err;
    int m_phase;

    function automatic int lookup(input int q);
        for (int i = 0; i < 8; i++) if (codes[i] == q) return i;
        return -1;
    endfunction

    task automatic model_step(input bit sn, input bit e, input int q);
        int  k;
        bit  fault;
        if (!sn) begin
            m_mode = 0; m_idx = 0; m_good = 0; m_errc = 0; m_rev = 0;
            m_locked = 0; m_wrap = 0; m_err = 0; m_phase = 0;
            return;
        end
        m_wrap = 0;
        if (!e) begin
`ifndef JPM_STICKY_ERR_EN
            m_err = 0;
`endif
            return;
        end
        k = lookup(q);
        fault = 0;
        if (m_mode == 0) begin
            if (k >= 0) begin m_idx = k; m_phase = 1 << k; m_good = 0; m_mode = 1; end
            else m_phase = 0;
        end else if (m_mode == 1) begin
            if (k < 0) begin m_phase = 0; m_good = 0; m_mode = 0; end
            else if (k == (m_idx + 1) % 8) begin
                m_good++; m_idx = k; m_phase = 1 << k;
                if (m_good == LOCK_CNT) m_mode = 2;
            end else begin m_idx = k; m_phase = 1 << k; m_good = 0; end
        end else begin
            if (k >= 0 && k == (m_idx + 1) % 8) begin
                if (m_idx == 7) begin m_wrap = 1; m_rev = (m_rev + 1) % 256; end
                m_idx = k; m_phase = 1 << k;
            end else begin
                fault = 1;
                m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                if (k >= 0) begin m_idx = k; m_phase = 1 << k; m_good = 0; m_mode = 1; end
                else begin m_phase = 0; m_mode = 0; end
            end
        end
        m_locked = (m_mode == 2);
`ifdef JPM_STICKY_ERR_EN
        m_err = m_err | fault;
`else
        m_err = fault;
`endif
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input bit sn, input bit e, input int q);
        @(negedge clk);
        start_n = sn; en = e; q_in = 4'(q);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit sn, input bit e, input int q);
        drive(sn, e, q);
        model_step(sn, e, q);
        chk("phase",     int'(phase),     m_phase);
        chk("phase_idx", int'(phase_idx), m_idx);
        chk("locked",    int'(locked),    int'(m_locked));
        chk("wrap",      int'(wrap),      int'(m_wrap));
        chk("err",       int'(err),       int'(m_err));
        chk("err_cnt",   int'(err_cnt),   m_errc);
        chk("rev_cnt",   int'(rev_cnt),   m_rev);
    endtask

    typedef struct {
        bit sn; bit e; int q;
        int ph; int idx; int lk; int wr; int er; int ec; int rv;
    } vec_t;

    function automatic vec_t mk(input bit sn, input bit e, input int q, input int ph, input int idx,
                                input int lk, input int wr, input int er, input int ec, input int rv);
        vec_t v;
        v.sn = sn; v.e = e; v.q = q; v.ph = ph; v.idx = idx;
        v.lk = lk; v.wr = wr; v.er = er; v.ec = ec; v.rv = rv;
        return v;
    endfunction

    initial begin
        vec_t tbl[31];
        int   cur, k, r, q, guard, exp_err;

        //          sn e  q      phase idx lk wr er ec rv
        tbl[0]  = mk(0, 1, 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 4'h0, 8'h01, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 4'h1, 8'h02, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 4'h3, 8'h04, 2, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 1, 4'h7, 8'h08, 3, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 4'hF, 8'h10, 4, 1, 0, 0, 0, 0);
        tbl[6]  = mk(1, 1, 4'hE, 8'h20, 5, 1, 0, 0, 0, 0);
        tbl[7]  = mk(1, 1, 4'hC, 8'h40, 6, 1, 0, 0, 0, 0);
        tbl[8]  = mk(1, 1, 4'h8, 8'h80, 7, 1, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 4'h0, 8'h01, 0, 1, 1, 0, 0, 1);
        tbl[10] = mk(1, 1, 4'h1, 8'h02, 1, 1, 0, 0, 0, 1);
        tbl[11] = mk(1, 1, 4'h3, 8'h04, 2, 1, 0, 0, 0, 1);
        tbl[12] = mk(1, 1, 4'h5, 8'h00, 2, 0, 0, 1, 1, 1);
        tbl[13] = mk(1, 1, 4'hF, 8'h10, 4, 0, 0, 0, 1, 1);
        tbl[14] = mk(1, 1, 4'hE, 8'h20, 5, 0, 0, 0, 1, 1);
        tbl[15] = mk(1, 1, 4'hC, 8'h40, 6, 0, 0, 0, 1, 1);
        tbl[16] = mk(1, 1, 4'h8, 8'h80, 7, 0, 0, 0, 1, 1);
        tbl[17] = mk(1, 1, 4'h0, 8'h01, 0, 1, 0, 0, 1, 1);
        tbl[18] = mk(1, 1, 4'h1, 8'h02, 1, 1, 0, 0, 1, 1);
        tbl[19] = mk(1, 1, 4'h3, 8'h04, 2, 1, 0, 0, 1, 1);
        tbl[20] = mk(1, 1, 4'h7, 8'h08, 3, 1, 0, 0, 1, 1);
        tbl[21] = mk(1, 1, 4'hF, 8'h10, 4, 1, 0, 0, 1, 1);
        tbl[22] = mk(1, 1, 4'hF, 8'h10, 4, 0, 0, 1, 2, 1);
        tbl[23] = mk(1, 1, 4'hE, 8'h20, 5, 0, 0, 0, 2, 1);
        tbl[24] = mk(1, 1, 4'hC, 8'h40, 6, 0, 0, 0, 2, 1);
        tbl[25] = mk(1, 1, 4'h8, 8'h80, 7, 0, 0, 0, 2, 1);
        tbl[26] = mk(1, 1, 4'h0, 8'h01, 0, 1, 0, 0, 2, 1);
        tbl[27] = mk(1, 0, 4'h5, 8'h01, 0, 1, 0, 0, 2, 1);
        tbl[28] = mk(1, 0, 4'hB, 8'h01, 0, 1, 0, 0, 2, 1);
        tbl[29] = mk(1, 0, 4'h9, 8'h01, 0, 1, 0, 0, 2, 1);
        tbl[30] = mk(1, 1, 4'h1, 8'h02, 1, 1, 0, 0, 2, 1);

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].sn, tbl[i].e, tbl[i].q);
            model_step(tbl[i].sn, tbl[i].e, tbl[i].q);
`ifdef JPM_STICKY_ERR_EN
            exp_err = (tbl[i].ec != 0) ? 1 : 0;
`else
            exp_err = tbl[i].er;
`endif
            chk("tbl_phase",   int'(phase),     tbl[i].ph);
            chk("tbl_idx",     int'(phase_idx), tbl[i].idx);
            chk("tbl_locked",  int'(locked),    tbl[i].lk);
            chk("tbl_wrap",    int'(wrap),      tbl[i].wr);
            chk("tbl_err",     int'(err),       exp_err);
            chk("tbl_err_cnt", int'(err_cnt),   tbl[i].ec);
            chk("tbl_rev_cnt", int'(rev_cnt),   tbl[i].rv);
        end

        // Randomized traffic: mostly clean sequence with stalls, glitches, gaps and resets.
        step(0, 1, 0);
        cur = 7;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(0, 1, $urandom_range(0, 15));
            end else if (r < 15) begin
                step(1, 0, $urandom_range(0, 15));
            end else begin
                if (r < 21) q = $urandom_range(0, 15);
                else if (r < 26) q = codes[cur];
                else q = codes[(cur + 1) % 8];
                step(1, 1, q);
                k = lookup(q);
                if (k >= 0) cur = k;
            end
        end

        // Saturation: 256 stall faults, each from a fresh lock.
        step(0, 1, 0);
        cur = 7;
        for (int f = 1; f <= 256; f++) begin
            guard = 0;
            while (!locked && guard < 12) begin
                cur = (cur + 1) % 8;
                step(1, 1, codes[cur]);
                guard++;
            end
            chk("lock_before_fault", int'(locked), 1);
            step(1, 1, codes[cur]);
            if (f == 255) chk("err_cnt_255", int'(err_cnt), 255);
            if (f == 256) chk("err_cnt_sat", int'(err_cnt), 255);
        end

        // Reset mid-revolution at idx 6, with prior faults outstanding.
        guard = 0;
        while (!(locked && phase_idx == 3'd6) && guard < 20) begin
            cur = (cur + 1) % 8;
            step(1, 1, codes[cur]);
            guard++;
        end
        chk("locked_at_idx6", int'(locked && phase_idx == 3'd6), 1);
        step(0, 1, codes[(cur + 1) % 8]);
        chk("rst_phase",   int'(phase),   0);
        chk("rst_locked",  int'(locked),  0);
        chk("rst_err",     int'(err),     0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_rev_cnt", int'(rev_cnt), 0);
        step(1, 1, codes[(cur + 1) % 8]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
